psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_pkg.sv | 28 ++
 rtl/psum_skid_fifo.sv | 51 +++++
 rtl/psum_drain.sv | 167 ++++++++++++++++
 tb/tb_psum_drain.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, drain FSM state encoding and skid-buffer helpers
// used by the psum drain path (DATA_WIDTH default also used by psum_manager).
package psum_pkg;

  // Default widths for the psum bank subsystem.
  localparam int PSUM_DATA_WIDTH = 32;
  localparam int DEF_BANK_COUNT  = 6;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_GPR_WIDTH   = 6;

  // Output skid buffer depth; the read credit limit is tied to it.
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    FLUSH   = 2'd2,
    RELEASE = 2'd3
  } drain_state_t;

  // Buffer occupancy after this cycle's push/pop (a fall-through pass keeps it).
  function automatic logic [2:0] occupancy_after(input logic [1:0] count,
                                                 input logic push,
                                                 input logic pop);
    return {1'b0, count} + {2'b00, push} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// psum_skid_fifo: 2-entry in-order buffer with first-word fall-through.
// When empty, a pushed word is visible on data in the same cycle, and a
// simultaneous pop passes it straight through without storing it.
module psum_skid_fifo
  import psum_pkg::*;
#(
  parameter int WIDTH = PSUM_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             empty;
  logic             store;
  logic             deq;

  assign empty = (count == 2'd0);
  assign valid = !empty || push;
  assign data  = empty ? push_data : mem[rd_ptr];

  // A push into an empty buffer that is popped the same cycle bypasses storage.
  assign store = push && !(empty && pop);
  assign deq   = pop && !empty;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: streams entries 0..N-1 of a finished psum bank out through a
// ready/valid port, then pulses bank_release/drain_done for one cycle.
// Reads are credit limited so buffered plus in-flight words never exceed two.
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative output words to 0.
module psum_drain
  import psum_pkg::*;
#(
  parameter int TOTAL_BANK_COUNT = DEF_BANK_COUNT,
  parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT),
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int GPR_WIDTH        = DEF_GPR_WIDTH,
  parameter int DATA_WIDTH       = PSUM_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        drain_req,
  input  logic [BANK_INDEX_WIDTH-1:0] drain_bank_index,
  input  logic [ADDR_WIDTH-1:0]       drain_length,
  input  logic [GPR_WIDTH-1:0]        drain_op_id,
  output logic                        drain_busy,
  output logic                        mem_rd_en,
  output logic [BANK_INDEX_WIDTH-1:0] mem_rd_bank_index,
  output logic [ADDR_WIDTH-1:0]       mem_rd_address,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [GPR_WIDTH-1:0]        out_op_id,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        bank_release,
  output logic [BANK_INDEX_WIDTH-1:0] bank_release_index,
  output logic                        drain_done
);

  drain_state_t                state;
  logic [BANK_INDEX_WIDTH-1:0] bank_q;
  logic [ADDR_WIDTH-1:0]       len_q;
  logic [GPR_WIDTH-1:0]        op_q;
  logic [ADDR_WIDTH-1:0]       rd_addr;

  // read issued last cycle; its data is on mem_rd_data now
  logic                        rd_inflight;
  logic                        rd_inflight_last;

  logic                        fifo_valid;
  logic [DATA_WIDTH:0]         fifo_word;
  logic [1:0]                  fifo_count;
  logic                        push;
  logic                        pop;
  logic                        fire_last;
  logic [DATA_WIDTH-1:0]       word;
  logic [DATA_WIDTH-1:0]       shaped;

  logic [2:0]                  count_next;
  logic [ADDR_WIDTH:0]         addr_next;
  logic                        last_addr;
  logic                        can_issue;

  assign push      = rd_inflight;
  assign pop       = fifo_valid && out_ready;
  assign fire_last = pop && fifo_word[DATA_WIDTH];

  // Next-cycle view of the credit: buffer occupancy after this edge plus the
  // read (if any) issued this cycle, which will be in flight next cycle.
  assign count_next = occupancy_after(fifo_count, push, pop);
  assign addr_next  = {1'b0, rd_addr} + (ADDR_WIDTH+1)'(mem_rd_en);
  assign last_addr  = ({1'b0, rd_addr} + (ADDR_WIDTH+1)'(1)) == {1'b0, len_q};
  assign can_issue  = (addr_next < {1'b0, len_q}) &&
                      ((count_next + 3'(mem_rd_en)) < 3'(SKID_DEPTH));

  // drain sequencing; read enable/address are registered one cycle ahead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bank_q       <= '0;
      len_q        <= '0;
      op_q         <= '0;
      rd_addr      <= '0;
      mem_rd_en    <= 1'b0;
      drain_busy   <= 1'b0;
      bank_release <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      bank_release <= 1'b0;
      drain_done   <= 1'b0;
      mem_rd_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_req) begin
            bank_q     <= drain_bank_index;
            len_q      <= drain_length;
            op_q       <= drain_op_id;
            rd_addr    <= '0;
            drain_busy <= 1'b1;
            if (drain_length != '0) begin
              state     <= READ;
              mem_rd_en <= 1'b1;
            end else begin
              state        <= RELEASE;
              bank_release <= 1'b1;
              drain_done   <= 1'b1;
            end
          end
        end
        READ: begin
          rd_addr   <= addr_next[ADDR_WIDTH-1:0];
          mem_rd_en <= can_issue;
          if (addr_next == {1'b0, len_q}) state <= FLUSH;
        end
        FLUSH: begin
          if (fire_last) begin
            state        <= RELEASE;
            bank_release <= 1'b1;
            drain_done   <= 1'b1;
          end
        end
        RELEASE: begin
          state      <= IDLE;
          drain_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in-flight read tracking; an async reset drops whatever was in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= mem_rd_en;
      rd_inflight_last <= mem_rd_en && last_addr;
    end
  end

  psum_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({rd_inflight_last, mem_rd_data}),
    .pop      (pop),
    .valid    (fifo_valid),
    .data     (fifo_word),
    .count    (fifo_count)
  );

  assign word = fifo_word[DATA_WIDTH-1:0];

`ifdef PSUM_DRAIN_RELU_EN
  assign shaped = word[DATA_WIDTH-1] ? '0 : word;
`else
  assign shaped = word;
`endif

  // Output fields are forced to zero whenever nothing is valid.
  assign out_valid          = fifo_valid;
  assign out_data           = fifo_valid ? shaped : '0;
  assign out_op_id          = fifo_valid ? op_q : '0;
  assign out_last           = fifo_valid && fifo_word[DATA_WIDTH];
  assign mem_rd_bank_index  = bank_q;
  assign mem_rd_address     = rd_addr;
  assign bank_release_index = bank_release ? bank_q : '0;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: randomized checks of psum_drain against a behavioural model:
// a drain of bank b, length N, op o must deliver relu?(bank[b][0..N-1]) in
// order tagged o, last on the final word, then release b exactly once.
module tb_psum_drain;
  localparam int NB = 6;
  localparam int BW = 3;
  localparam int AW = 8;
  localparam int GW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          drain_req = 1'b0;
  logic [BW-1:0] drain_bank_index = '0;
  logic [AW-1:0] drain_length = '0;
  logic [GW-1:0] drain_op_id = '0;
  logic          drain_busy;
  logic          mem_rd_en;
  logic [BW-1:0] mem_rd_bank_index;
  logic [AW-1:0] mem_rd_address;
  logic [DW-1:0] mem_rd_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [GW-1:0] out_op_id;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          bank_release;
  logic [BW-1:0] bank_release_index;
  logic          drain_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] bank_mem [NB][256];

  psum_drain #(
    .TOTAL_BANK_COUNT(NB), .BANK_INDEX_WIDTH(BW), .ADDR_WIDTH(AW),
    .GPR_WIDTH(GW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .drain_req(drain_req),
    .drain_bank_index(drain_bank_index), .drain_length(drain_length),
    .drain_op_id(drain_op_id), .drain_busy(drain_busy), .mem_rd_en(mem_rd_en),
    .mem_rd_bank_index(mem_rd_bank_index), .mem_rd_address(mem_rd_address),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_op_id(out_op_id), .out_last(out_last), .out_ready(out_ready),
    .bank_release(bank_release), .bank_release_index(bank_release_index),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bank memory: data one cycle after the read, garbage otherwise
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? bank_mem[mem_rd_bank_index][mem_rd_address] : 32'hDEADBEEF;

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w);
`ifdef PSUM_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // monitor: transfers, reads, releases and protocol violations
  typedef struct { logic [DW-1:0] d; logic [GW-1:0] op; logic last; int c; } xfer_t;
  xfer_t xq[$];
  int    rdq[$];
  int    relq[$];
  int    relc[$];
  int    n_iss = 0, n_xfer = 0, n_valid = 0;
  int    viol_stable = 0, viol_occ = 0, viol_rd = 0, viol_done = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      n_iss = n_xfer;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) viol_stable++;
      if ((n_iss - n_xfer > 2) || (mem_rd_en && (n_iss - n_xfer >= 2))) viol_occ++;
      if (mem_rd_en && !drain_busy) viol_rd++;
      if (drain_done !== bank_release) viol_done++;
      if (out_valid) n_valid++;
      if (out_valid && out_ready) begin
        xq.push_back('{out_data, out_op_id, out_last, cyc});
        n_xfer++;
      end
      if (mem_rd_en) begin
        rdq.push_back(int'(mem_rd_address));
        n_iss++;
      end
      if (bank_release) begin
        relq.push_back(int'(bank_release_index));
        relc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Presents one drain request (called just after a rising edge) and runs it
  // to its release; mode 0: ready high, 1: ready 1,0,0 repeating, 2: random.
  task automatic do_drain(input int b, input int n, input int op, input int mode, input bit spam,
                          output int req_c, output int xb, output int rb, output int lb,
                          output bit tmo);
    int budget;
    xb = xq.size(); rb = rdq.size(); lb = relq.size();
    drain_req = 1'b1;
    drain_bank_index = BW'(b);
    drain_length = AW'(n);
    drain_op_id = GW'(op);
    req_c = cyc;
    tmo = 1'b1;
    budget = 4 * n + 40;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (bank_release) begin
        tmo = 1'b0;
        drain_req = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        break;
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (k % 3 == 0);
      else out_ready = 1'($urandom_range(0, 1));
      if (spam) begin
        drain_req = 1'($urandom_range(0, 1));
        drain_bank_index = BW'($urandom_range(0, NB - 1));
        drain_length = AW'($urandom_range(0, 255));
        drain_op_id = GW'($urandom_range(0, 63));
      end else begin
        drain_req = 1'b0;
      end
    end
    drain_req = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({drain_busy, mem_rd_en, mem_rd_bank_index, mem_rd_address, out_valid, out_data,
         out_op_id, out_last, bank_release, bank_release_index, drain_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rd_en=%b valid=%b data=%0h release=%b, all required 0",
               drain_busy, mem_rd_en, out_valid, out_data, bank_release);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (drain_busy !== 1'b0 || out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b valid=%b rd_en=%b, required 0",
               drain_busy, out_valid, mem_rd_en);
    end
  endtask

  task automatic test_basic();
    int req_c, xb, rb, lb;
    bit tmo;
    for (int i = 0; i < 4; i++) bank_mem[3][i] = DW'(10 * (i + 1));
    do_drain(3, 4, 21, 0, 1'b0, req_c, xb, rb, lb, tmo);
    n_tests++;
    if (tmo || xq.size() - xb != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d transfers timeout=%b, required 4", xq.size() - xb, tmo);
    end
    for (int i = 0; i < 4; i++) if (xb + i < xq.size()) begin
      n_tests++;
      if (xq[xb+i].d !== DW'(10 * (i + 1)) || xq[xb+i].op !== GW'(21) ||
          xq[xb+i].last !== (i == 3) || xq[xb+i].c != req_c + 2 + i) begin
        n_fail++;
        $display("FAIL basic_word%0d: got data=%0d op=%0d last=%b cycle=+%0d, required %0d/21/%b/+%0d",
                 i, xq[xb+i].d, xq[xb+i].op, xq[xb+i].last, xq[xb+i].c - req_c,
                 10 * (i + 1), (i == 3), 2 + i);
      end
    end
    n_tests++;
    if (relq.size() != lb + 1 || relq[lb] != 3 || relc[lb] != req_c + 6) begin
      n_fail++;
      $display("FAIL basic_release: got %0d releases, required one of index 3 at +6", relq.size() - lb);
    end
    n_tests++;
    if (rdq.size() != rb + 4 || rdq[rb] != 0 || rdq[rb+3] != 3) begin
      n_fail++;
      $display("FAIL basic_reads: got %0d reads, required addresses 0..3", rdq.size() - rb);
    end
  endtask

  task automatic test_backpressure();
    int req_c, xb, rb, lb, vs, vo;
    bit tmo;
    vs = viol_stable; vo = viol_occ;
    for (int i = 0; i < 4; i++) bank_mem[1][i] = $urandom;
    do_drain(1, 4, 7, 1, 1'b0, req_c, xb, rb, lb, tmo);
    n_tests++;
    if (tmo || xq.size() - xb != 4 || rdq.size() - rb != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d transfers %0d reads, required 4 and 4", xq.size() - xb, rdq.size() - rb);
    end
    for (int i = 0; i < 4; i++) if (xb + i < xq.size()) begin
      n_tests++;
      if (xq[xb+i].d !== ref_word(bank_mem[1][i]) || xq[xb+i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %0h last=%b, required %0h last=%b",
                 i, xq[xb+i].d, xq[xb+i].last, ref_word(bank_mem[1][i]), (i == 3));
      end
    end
    n_tests++;
    if (viol_stable != vs || viol_occ != vo) begin
      n_fail++;
      $display("FAIL bp_protocol: got %0d unstable stalls %0d credit overruns, required 0",
               viol_stable - vs, viol_occ - vo);
    end
    n_tests++;
    if (relq.size() != lb + 1 || relq[lb] != 1) begin
      n_fail++;
      $display("FAIL bp_release: got %0d releases, required one of index 1", relq.size() - lb);
    end
  endtask

  task automatic test_zero_len();
    int nv, rb;
    nv = n_valid; rb = rdq.size();
    drain_req = 1'b1; drain_bank_index = 3'd5; drain_length = '0; drain_op_id = 6'd9;
    @(posedge clk); #1;
    drain_req = 1'b0;
    n_tests++;
    if (bank_release !== 1'b1 || drain_done !== 1'b1 || bank_release_index !== 3'd5 || drain_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_release: got release=%b done=%b idx=%0d busy=%b, required 1/1/5/1",
               bank_release, drain_done, bank_release_index, drain_busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bank_release !== 1'b0 || drain_busy !== 1'b0 || n_valid != nv || rdq.size() != rb) begin
      n_fail++;
      $display("FAIL zero_after: got release=%b busy=%b valid_cycles=%0d reads=%0d, required all 0",
               bank_release, drain_busy, n_valid - nv, rdq.size() - rb);
    end
  endtask

  task automatic test_relu();
    int req_c, xb, rb, lb;
    bit tmo;
    logic [DW-1:0] exp0;
`ifdef PSUM_DRAIN_RELU_EN
    exp0 = '0;
`else
    exp0 = 32'hFFFFFFFB;
`endif
    bank_mem[2][0] = 32'hFFFFFFFB;
    bank_mem[2][1] = 32'd7;
    do_drain(2, 2, 3, 0, 1'b0, req_c, xb, rb, lb, tmo);
    n_tests++;
    if (tmo || xq.size() - xb != 2 || xq[xb].d !== exp0 || xq[xb+1].d !== 32'd7) begin
      n_fail++;
      $display("FAIL relu_data: got %0d words first=%0h, required 2 words first=%0h second=7",
               xq.size() - xb, (xq.size() > xb) ? xq[xb].d : 32'h0, exp0);
    end
  endtask

  task automatic test_reset_mid();
    int req_c, xb, rb, lb;
    bit tmo, found;
    for (int i = 0; i < 8; i++) bank_mem[4][i] = $urandom;
    rb = rdq.size(); lb = relq.size();
    drain_req = 1'b1; drain_bank_index = 3'd4; drain_length = 8'd8; drain_op_id = 6'd33;
    @(posedge clk); #1;
    drain_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rdq.size() - rb >= 2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_reads: got %0d reads, required 2 before reset", rdq.size() - rb);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({drain_busy, mem_rd_en, mem_rd_address, out_valid, out_data, out_op_id, out_last,
         bank_release, bank_release_index, drain_done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b rd_en=%b valid=%b data=%0h, required 0",
               drain_busy, mem_rd_en, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (relq.size() != lb || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_norelease: got %0d releases valid=%b, required 0 and 0", relq.size() - lb, out_valid);
    end
    do_drain(4, 8, 12, 0, 1'b0, req_c, xb, rb, lb, tmo);
    n_tests++;
    if (tmo || xq.size() - xb != 8 || relq.size() != lb + 1 || relq[lb] != 4) begin
      n_fail++;
      $display("FAIL midreset_redrain: got %0d words %0d releases, required 8 and 1", xq.size() - xb, relq.size() - lb);
    end
    for (int i = 0; i < 8; i++) if (xb + i < xq.size()) begin
      n_tests++;
      if (xq[xb+i].d !== ref_word(bank_mem[4][i]) || xq[xb+i].op !== GW'(12) || xq[xb+i].c != req_c + 2 + i) begin
        n_fail++;
        $display("FAIL midreset_word%0d: got %0h op=%0d at +%0d, required %0h op=12 at +%0d",
                 i, xq[xb+i].d, xq[xb+i].op, xq[xb+i].c - req_c, ref_word(bank_mem[4][i]), 2 + i);
      end
    end
  endtask

  task automatic test_busy_max();
    int req_c, xb, rb, lb, errs, vs, vo, vr;
    bit tmo;
    vs = viol_stable; vo = viol_occ; vr = viol_rd;
    for (int i = 0; i < 256; i++) bank_mem[0][i] = $urandom;
    do_drain(0, 255, 45, 2, 1'b1, req_c, xb, rb, lb, tmo);
    n_tests++;
    if (tmo || xq.size() - xb != 255 || rdq.size() - rb != 255) begin
      n_fail++;
      $display("FAIL max_count: got %0d words %0d reads timeout=%b, required 255 and 255",
               xq.size() - xb, rdq.size() - rb, tmo);
    end
    errs = 0;
    for (int i = 0; i < 255; i++) begin
      if (xb + i >= xq.size() || rb + i >= rdq.size()) break;
      if (xq[xb+i].d !== ref_word(bank_mem[0][i]) || xq[xb+i].op !== GW'(45) ||
          xq[xb+i].last !== (i == 254) || rdq[rb+i] != i) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL max_stream: got %0d bad words/addresses, required 0", errs);
    end
    n_tests++;
    if (relq.size() != lb + 1 || relq[lb] != 0 || viol_stable != vs || viol_occ != vo || viol_rd != vr) begin
      n_fail++;
      $display("FAIL max_release_protocol: got %0d releases, %0d/%0d/%0d violations, required 1 and 0/0/0",
               relq.size() - lb, viol_stable - vs, viol_occ - vo, viol_rd - vr);
    end
  endtask

  task automatic test_back_to_back();
    int req_c, xb, rb, lb, b, n, op, mode;
    bit tmo;
    for (int t = 0; t < 6; t++) begin
      b = $urandom_range(0, NB - 1);
      n = (t == 2) ? 0 : $urandom_range(1, 12);
      op = $urandom_range(0, 63);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) bank_mem[b][i] = $urandom;
      do_drain(b, n, op, mode, 1'b0, req_c, xb, rb, lb, tmo);
      n_tests++;
      if (tmo || xq.size() - xb != n || relq.size() != lb + 1 || relq[lb] != b) begin
        n_fail++;
        $display("FAIL b2b%0d_count: got %0d words %0d releases, required %0d words 1 release of %0d",
                 t, xq.size() - xb, relq.size() - lb, n, b);
      end
      for (int i = 0; i < n; i++) if (xb + i < xq.size()) begin
        n_tests++;
        if (xq[xb+i].d !== ref_word(bank_mem[b][i]) || xq[xb+i].op !== GW'(op) || xq[xb+i].last !== (i == n - 1)) begin
          n_fail++;
          $display("FAIL b2b%0d_word%0d: got %0h op=%0d last=%b, required %0h op=%0d last=%b",
                   t, i, xq[xb+i].d, xq[xb+i].op, xq[xb+i].last, ref_word(bank_mem[b][i]), op, (i == n - 1));
        end
      end
      if (mode == 0 && n > 0 && xq.size() > xb) begin
        n_tests++;
        if (xq[xb].c != req_c + 2 || relc[lb] != req_c + 2 + n) begin
          n_fail++;
          $display("FAIL b2b%0d_latency: got first +%0d release +%0d, required +2 and +%0d",
                   t, xq[xb].c - req_c, relc[lb] - req_c, 2 + n);
        end
      end
    end
    n_tests++;
    if (viol_done != 0 || viol_rd != 0) begin
      n_fail++;
      $display("FAIL b2b_protocol: got %0d done/release splits %0d idle reads, required 0", viol_done, viol_rd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_relu();
    test_reset_mid();
    test_busy_max();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
